// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
`timescale 1ns/1ps
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  // Parity options. The numeric order matches the PARITY_MODE parameter (0/1/2).
  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  // 2-of-3 majority vote used to decide each bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// It resets to 1 so that a line in reset looks idle.
`timescale 1ns/1ps
module uart_bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic rxd,
  output logic rxd_s
);

  logic meta;

  // Shift the raw line through two flops to resolve metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta  <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep this a true two-stage pipeline; blocking would collapse it to one flop.
      meta  <= rxd;
      rxd_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver.
// Features:
//  - configurable data width, parity and number of stop bits;
//  - 3-sample majority vote per bit;
//  - parity, framing, overrun and break reporting;
//  - valid/ready output.
`timescale 1ns/1ps
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 1_000_000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int MID   = DIV / 2;
  localparam int CNT_W = $clog2(DIV);

  localparam parity_e PAR_CFG = (PARITY_MODE == 1) ? PAR_EVEN :
                                (PARITY_MODE == 2) ? PAR_ODD  : PAR_NONE;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SA   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_SB   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
  localparam logic [3:0]       DATA_LST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LST = 4'(STOP_BITS - 1);

  // Reject configurations the sampling scheme cannot support.
  if (DIV < 8) begin : g_div_check
    $error("uart_rx_param: CLK_FREQ/BAUD_RATE must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_par_check
    $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
  end

  rx_state_e            state, state_next;
  logic                 rxd_s;
  logic                 armed;
  logic [CNT_W-1:0]     sample_cnt;
  logic [3:0]           bit_cnt;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 parity_err_next;
  logic                 frame_err_next;

  logic bit_end, decide, vote;
  logic last_data, first_stop, last_stop;
  logic par_expect, break_hit, commit, frame_err_final;

  uart_bit_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .rxd_s (rxd_s)
  );

  assign bit_end    = (sample_cnt == CNT_LAST);
  assign decide     = (sample_cnt == CNT_DEC);
  assign vote       = maj3(samp_a, samp_b, rxd_s);
  assign last_data  = (bit_cnt == DATA_LST);
  assign first_stop = (bit_cnt == 4'd0);
  assign last_stop  = (bit_cnt == STOP_LST);

  // Arm on the first idle level after reset, so a frame already in flight is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      armed <= 1'b0;
    else if (rxd_s) armed <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment up front guarantees every path drives state_next, so no latch is inferred.
    state_next = state;
    case (state)
      IDLE:   if (armed && !rxd_s) state_next = START;
      START: begin
        if (decide && vote) state_next = IDLE;   // line went back high: glitch
        else if (bit_end)   state_next = DATA;
      end
      DATA:   if (bit_end && last_data)
                state_next = (PAR_CFG == PAR_NONE) ? STOP : PARITY;
      PARITY: if (bit_end) state_next = STOP;
      STOP: begin
        if (break_hit)   state_next = BREAK;
        else if (commit) state_next = IDLE;
      end
      BREAK:  if (rxd_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/decode logic: status, parity expectation, and frame end events.
  always_comb begin
    busy            = (state != IDLE);
    par_expect      = (PAR_CFG == PAR_ODD) ? ~^shift_reg : ^shift_reg;
    break_hit       = (state == STOP) && decide && first_stop && (shift_reg == '0) &&
                      ((PAR_CFG == PAR_NONE) || !par_bit) && !vote;
    commit          = (state == STOP) && decide && last_stop && !break_hit;
    frame_err_final = frame_err_next | ~vote;
  end

  // Bit timing, sample capture, data shifting and error accumulation for the current frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt      <= '0;
      bit_cnt         <= '0;
      samp_a          <= 1'b1;
      samp_b          <= 1'b1;
      shift_reg       <= '0;
      par_bit         <= 1'b0;
      parity_err_next <= 1'b0;
      frame_err_next  <= 1'b0;
    end else if (state == IDLE || state == BREAK) begin
      sample_cnt      <= '0;
      bit_cnt         <= '0;
      par_bit         <= 1'b0;
      parity_err_next <= 1'b0;
      frame_err_next  <= 1'b0;
    end else begin
      sample_cnt <= bit_end ? '0 : sample_cnt + 1'b1;
      if (sample_cnt == CNT_SA) samp_a <= rxd_s;
      if (sample_cnt == CNT_SB) samp_b <= rxd_s;

      // bit_cnt counts data bits in DATA, then restarts to count stop bits in STOP.
      if (bit_end && state == DATA)
        bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
      else if (bit_end && state == STOP)
        bit_cnt <= bit_cnt + 4'd1;

      if (decide) begin
        case (state)
          DATA:   shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
          PARITY: begin
            par_bit         <= vote;
            parity_err_next <= (vote != par_expect);
          end
          STOP:   if (!vote) frame_err_next <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Output register and valid/ready handshake, with overrun and break pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      break_det   <= break_hit;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_reg;
          parity_err <= parity_err_next;
          frame_err  <= frame_err_final;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;     // consumer still holds the previous frame
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param.
// Three instances cover 8N1, 8E1 and 7O2 at 50 clocks per bit.
// Expected results come from a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int DIV = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rxd;
  logic [2:0] rx_ready;
  wire  [7:0] d0, d1;
  wire  [6:0] d2;
  wire  [2:0] valid, perr, ferr, ovr, brk, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int brk_cnt[3];
  int ovr_cnt[3];

  always #10 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(50_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .rxd(rxd[0]), .rx_data(d0), .rx_valid(valid[0]),
    .rx_ready(rx_ready[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
    .overrun_err(ovr[0]), .break_det(brk[0]), .busy(busy[0]));

  uart_rx_param #(.CLK_FREQ(50_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                  .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .rxd(rxd[1]), .rx_data(d1), .rx_valid(valid[1]),
    .rx_ready(rx_ready[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
    .overrun_err(ovr[1]), .break_det(brk[1]), .busy(busy[1]));

  uart_rx_param #(.CLK_FREQ(50_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                  .PARITY_MODE(2), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .reset(reset), .rxd(rxd[2]), .rx_data(d2), .rx_valid(valid[2]),
    .rx_ready(rx_ready[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
    .overrun_err(ovr[2]), .break_det(brk[2]), .busy(busy[2]));

  // Count single-cycle pulses per channel.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset && brk[i]) brk_cnt[i]++;
      if (!reset && ovr[i]) ovr_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame format of each channel.
  function automatic int db_of(input int ch);
    return (ch == 2) ? 7 : 8;
  endfunction
  function automatic int pm_of(input int ch);
    return ch;   // ch0 none, ch1 even, ch2 odd
  endfunction
  function automatic int sb_of(input int ch);
    return (ch == 2) ? 2 : 1;
  endfunction

  function automatic logic [31:0] data_of(input int ch);
    case (ch)
      0:       return {24'd0, d0};
      1:       return {24'd0, d1};
      default: return {25'd0, d2};
    endcase
  endfunction

  typedef struct {
    logic        brk;
    logic [31:0] data;
    logic        pe;
    logic        fe;
  } exp_t;

  // Reference model: what a receiver should report for a clean frame with these field values.
  function automatic exp_t model(input int ch, input logic [8:0] data, input logic par_bit,
                                 input logic [1:0] stops);
    exp_t e;
    int   db = db_of(ch);
    int   pm = pm_of(ch);
    int   ones;
    logic [31:0] masked = {23'd0, data} & ((32'd1 << db) - 32'd1);
    ones   = $countones(masked);
    e.data = masked;
    if (pm == 0)      e.pe = 1'b0;
    else if (pm == 1) e.pe = ((ones + int'(par_bit)) % 2) != 0;
    else              e.pe = ((ones + int'(par_bit)) % 2) != 1;
    e.fe  = !stops[0] || (sb_of(ch) == 2 && !stops[1]);
    e.brk = (masked == 0) && (pm == 0 || !par_bit) && !stops[0];
    return e;
  endfunction

  function automatic logic good_parity(input int ch, input logic [8:0] data);
    logic [31:0] masked = {23'd0, data} & ((32'd1 << db_of(ch)) - 32'd1);
    logic        odd_ones = ($countones(masked) % 2) == 1;
    return (pm_of(ch) == 2) ? !odd_ones : odd_ones;
  endfunction

  // Holds one line level for n bit-clocks; the caller is aligned to a negedge.
  task automatic drive_level(input int ch, input logic b, input int n);
    rxd[ch] = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int ch, input logic [8:0] data, input logic par_bit,
                            input logic [1:0] stops);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < db_of(ch); i++) q.push_back(data[i]);
    if (pm_of(ch) != 0) q.push_back(par_bit);
    for (int i = 0; i < sb_of(ch); i++) q.push_back(stops[i]);
    foreach (q[i]) drive_level(ch, q[i], DIV);
    rxd[ch] = 1'b1;
  endtask

  task automatic wait_valid(input int ch, input string tag);
    int k = 0;
    while (!valid[ch] && k < 4 * DIV) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, {31'd0, valid[ch]}, 32'd1);
  endtask

  task automatic accept(input int ch, input string tag);
    rx_ready[ch] = 1'b1;
    @(negedge clk);
    rx_ready[ch] = 1'b0;
    check({tag, "_drop"}, {31'd0, valid[ch]}, 32'd0);
  endtask

  // Send a frame, then check the outcome against the model.
  task automatic run_frame(input int ch, input logic [8:0] data, input logic par_bit,
                           input logic [1:0] stops, input string tag);
    exp_t e  = model(ch, data, par_bit, stops);
    int   b0 = brk_cnt[ch];
    int   o0 = ovr_cnt[ch];
    send_frame(ch, data, par_bit, stops);
    if (e.brk) begin
      repeat (2 * DIV) @(negedge clk);
      check({tag, "_brk"}, 32'(brk_cnt[ch] - b0), 32'd1);
      check({tag, "_novalid"}, {31'd0, valid[ch]}, 32'd0);
    end else begin
      wait_valid(ch, tag);
      if (valid[ch]) begin
        check({tag, "_data"}, data_of(ch), e.data);
        check({tag, "_perr"}, {31'd0, perr[ch]}, {31'd0, e.pe});
        check({tag, "_ferr"}, {31'd0, ferr[ch]}, {31'd0, e.fe});
        accept(ch, tag);
      end
      check({tag, "_nobrk"}, 32'(brk_cnt[ch] - b0), 32'd0);
      repeat (2 * DIV) @(negedge clk);
    end
    check({tag, "_noovr"}, 32'(ovr_cnt[ch] - o0), 32'd0);
    check({tag, "_idle"}, {31'd0, busy[ch]}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, o0, ch;
    logic [8:0] data;
    logic       par;
    logic [1:0] stops;

    reset    = 1'b1;
    rxd      = 3'b111;
    rx_ready = 3'b000;
    repeat (5) @(negedge clk);
    check("rst_flags", {26'd0, valid, perr}, 32'd0);
    check("rst_err",   {26'd0, ferr, ovr}, 32'd0);
    check("rst_busy",  {26'd0, brk, busy}, 32'd0);
    check("rst_data",  {9'd0, d0, d1, d2}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Directed frames.
    run_frame(0, 9'h0A5, 1'b0, 2'b11, "8n1_a5");
    run_frame(1, 9'h03C, 1'b1, 2'b11, "8e1_badpar");
    run_frame(1, 9'h03C, 1'b0, 2'b11, "8e1_goodpar");
    run_frame(0, 9'h055, 1'b0, 2'b10, "8n1_badstop");
    run_frame(2, 9'h07F, 1'b0, 2'b11, "7o2_7f");

    // Short low pulse must be rejected as a glitch.
    b0 = brk_cnt[0];
    o0 = ovr_cnt[0];
    drive_level(0, 1'b0, 10);
    drive_level(0, 1'b1, 3 * DIV);
    check("glitch_novalid", {31'd0, valid[0]}, 32'd0);
    check("glitch_busy",    {31'd0, busy[0]}, 32'd0);
    check("glitch_flags",   32'(brk_cnt[0] - b0 + ovr_cnt[0] - o0), 32'd0);

    // Overrun: second frame arrives while the first is unread.
    o0 = ovr_cnt[0];
    send_frame(0, 9'h011, 1'b0, 2'b11);
    wait_valid(0, "ovr_first");
    send_frame(0, 9'h022, 1'b0, 2'b11);
    repeat (5) @(negedge clk);
    check("ovr_held_valid", {31'd0, valid[0]}, 32'd1);
    check("ovr_held_data",  data_of(0), 32'h11);
    check("ovr_pulses",     32'(ovr_cnt[0] - o0), 32'd1);
    accept(0, "ovr");
    repeat (2 * DIV) @(negedge clk);

    // Long low level is a break.
    b0 = brk_cnt[0];
    drive_level(0, 1'b0, 12 * DIV);
    drive_level(0, 1'b1, 2 * DIV);
    check("break_pulses",  32'(brk_cnt[0] - b0), 32'd1);
    check("break_novalid", {31'd0, valid[0]}, 32'd0);
    check("break_busy",    {31'd0, busy[0]}, 32'd0);

    // Reset in the middle of the data bits drops the frame.
    drive_level(0, 1'b0, DIV);
    drive_level(0, 1'b0, DIV);
    drive_level(0, 1'b1, DIV);
    drive_level(0, 1'b1, DIV / 2);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_out", {22'd0, d0, valid[0], busy[0]}, 32'd0);
    rxd[0] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_novalid", {31'd0, valid[0]}, 32'd0);
    run_frame(0, 9'h07E, 1'b0, 2'b11, "post_rst_7e");

    // Randomised frames across all formats.
    for (int n = 0; n < 24; n++) begin
      ch    = int'($urandom_range(0, 2));
      data  = 9'($urandom);
      par   = good_parity(ch, data);
      stops = 2'b11;
      if ($urandom_range(0, 3) == 0) par = ~par;
      if ($urandom_range(0, 6) == 0) stops[0] = 1'b0;
      if ($urandom_range(0, 6) == 0) stops[1] = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        data  = 9'd0;
        stops = 2'b00;
      end
      run_frame(ch, data, par, stops, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
